sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_if.sv | 50 +++++
 rtl/sdram_arbiter.sv | 131 +++++++++++++
 tb/tb_sdram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: request/response bundle between two bus masters,
// the arbiter and the SDRAM controller user port.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 23
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic              m0_ack;
  logic [31:0]       m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic              m1_ack;
  logic [31:0]       m1_rdata;

  logic [ADDR_W-1:0] ctl_addr;
  logic              ctl_rw;
  logic [31:0]       ctl_wdata;
  logic              ctl_in_valid;
  logic              ctl_busy;
  logic              ctl_out_valid;
  logic [31:0]       ctl_rdata;

  logic [1:0]        gnt;
  logic              err;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output ctl_addr, ctl_rw, ctl_wdata, ctl_in_valid,
    input  ctl_busy, ctl_out_valid, ctl_rdata,
    output gnt, err
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  ctl_addr, ctl_rw, ctl_wdata, ctl_in_valid,
    output ctl_busy, ctl_out_valid, ctl_rdata,
    input  gnt, err
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port arbiter in front of an SDRAM controller.
// Define SDRAM_ARB_RR_EN for round-robin; default is fixed priority.
module sdram_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    DONE
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        gnt_q;
  logic [1:0]        ack_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata0_q;
  logic [31:0]       rdata1_q;

  logic        any_req;
  logic        pick1;
  logic        accept;
  logic        rd_end;
  logic [31:0] rd_val;

  assign any_req = bus.m0_req | bus.m1_req;

`ifdef SDRAM_ARB_RR_EN
  // last = 1 when port 1 owned the most recent transaction
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 1'b0;
    else if (state == DONE)
      last <= gnt_q[1];
  end

  assign pick1 = bus.m1_req & (~bus.m0_req | ~last);
`else
  assign pick1 = bus.m1_req & ~bus.m0_req;
`endif

  assign accept = (state == ISSUE) & ~bus.ctl_busy;
  assign rd_end = bus.ctl_out_valid | (cnt == CNT_LAST);
  assign rd_val = bus.ctl_out_valid ? bus.ctl_rdata
                                    : 32'hDEAD_BEEF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt_q    <= 2'b00;
      ack_q    <= 2'b00;
      err_q    <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack_q <= 2'b00;
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= {pick1, ~pick1};
            rw_q    <= pick1 ? bus.m1_we : bus.m0_we;
            addr_q  <= pick1 ? bus.m1_addr : bus.m0_addr;
            wdata_q <= pick1 ? bus.m1_wdata : bus.m0_wdata;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            cnt <= '0;
            if (rw_q) begin
              ack_q <= gnt_q;
              state <= DONE;
            end else begin
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (rd_end) begin
            if (gnt_q[1])
              rdata1_q <= rd_val;
            else
              rdata0_q <= rd_val;
            err_q <= ~bus.ctl_out_valid;
            ack_q <= gnt_q;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          gnt_q <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ctl_in_valid = accept;
  assign bus.ctl_addr     = addr_q;
  assign bus.ctl_rw       = rw_q;
  assign bus.ctl_wdata    = wdata_q;
  assign bus.gnt          = gnt_q;
  assign bus.err          = err_q;
  assign bus.m0_ack       = ack_q[0];
  assign bus.m1_ack       = ack_q[1];
  assign bus.m0_rdata     = rdata0_q;
  assign bus.m1_rdata     = rdata1_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed stimulus with a scoreboard of expected
// controller strobes and master acks, checked by a negedge monitor.
module tb_sdram_arbiter;

  localparam int AW = 23;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_W(AW)) bus ();

  sdram_arbiter #(
    .ADDR_W (AW),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic [31:0]   wdata;
    logic [1:0]    gnt;
  } cmd_t;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  cmd_t mc;
  rsp_t mr;

  int n_chk = 0;
  int n_fail = 0;
  int n_strobe = 0;
  int last_port = 0;
  logic [31:0] model_rd[2];

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ctl_in_valid) begin
        n_strobe++;
        if (cmd_q.size() == 0) begin
          check("strobe_unexpected", bus.ctl_in_valid, 0);
        end else begin
          mc = cmd_q.pop_front();
          check("ctl_addr", bus.ctl_addr, mc.addr);
          check("ctl_rw", bus.ctl_rw, mc.rw);
          check("ctl_wdata", bus.ctl_wdata, mc.wdata);
          check("gnt_at_strobe", bus.gnt, mc.gnt);
        end
      end
      if (bus.m0_ack || bus.m1_ack) begin
        if (rsp_q.size() == 0) begin
          check("ack_unexpected", {bus.m1_ack, bus.m0_ack}, 0);
        end else begin
          mr = rsp_q.pop_front();
          check("ack_port", {bus.m1_ack, bus.m0_ack}, mr.ack);
          check("gnt_at_ack", bus.gnt, mr.ack);
          check("rdata", bus.m1_ack ? bus.m1_rdata : bus.m0_rdata,
                mr.rdata);
          check("err_at_ack", bus.err, mr.err);
        end
        last_port = bus.m1_ack ? 1 : 0;
      end else if (bus.err) begin
        check("err_stray", bus.err, 0);
      end
    end
  end

  task automatic drive(int p, logic req, logic we,
                       logic [AW-1:0] a, logic [31:0] d);
    if (p == 0) begin
      bus.m0_req = req; bus.m0_we = we;
      bus.m0_addr = a;  bus.m0_wdata = d;
    end else begin
      bus.m1_req = req; bus.m1_we = we;
      bus.m1_addr = a;  bus.m1_wdata = d;
    end
  endtask

  function automatic logic ackd(int p);
    return (p == 0) ? bus.m0_ack : bus.m1_ack;
  endfunction

  task automatic exp_xact(int p, logic we, logic [AW-1:0] a,
                          logic [31:0] d, logic [31:0] rd,
                          logic e);
    logic [1:0] g;
    g = (p == 0) ? 2'b01 : 2'b10;
    cmd_q.push_back('{addr: a, rw: we, wdata: d, gnt: g});
    if (!we) model_rd[p] = rd;
    rsp_q.push_back('{ack: g, rdata: model_rd[p], err: e});
  endtask

  task automatic xact(int p, logic we, logic [AW-1:0] a,
                      logic [31:0] d, int bound, output int lat);
    @(posedge clk); #1;
    drive(p, 1'b1, we, a, d);
    lat = 0;
    while (lat < bound) begin
      @(negedge clk);
      lat++;
      if (ackd(p)) break;
    end
    if (!ackd(p)) check("ack_timeout", ackd(p), 1);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic ctl_reply(int dly, logic [31:0] d,
                           logic [1:0] g, output int bad);
    int t;
    t = 0;
    bad = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.ctl_in_valid && t < 50);
    repeat (dly) begin
      @(posedge clk); #1;
      if (bus.gnt !== g) bad++;
    end
    bus.ctl_out_valid = 1'b1;
    bus.ctl_rdata = d;
    @(posedge clk); #1;
    bus.ctl_out_valid = 1'b0;
    bus.ctl_rdata = '0;
  endtask

  task automatic check_reset(string tag);
    check({tag, "_gnt"}, bus.gnt, 0);
    check({tag, "_in_valid"}, bus.ctl_in_valid, 0);
    check({tag, "_rw"}, bus.ctl_rw, 0);
    check({tag, "_addr"}, bus.ctl_addr, 0);
    check({tag, "_wdata"}, bus.ctl_wdata, 0);
    check({tag, "_acks"}, {bus.m1_ack, bus.m0_ack}, 0);
    check({tag, "_m0_rdata"}, bus.m0_rdata, 0);
    check({tag, "_m1_rdata"}, bus.m1_rdata, 0);
    check({tag, "_err"}, bus.err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int bad;
    int s0;
    int n;
    int t;
    int w;

    model_rd[0] = '0;
    model_rd[1] = '0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    bus.ctl_busy = 1'b0;
    bus.ctl_out_valid = 1'b0;
    bus.ctl_rdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // m0 write, controller idle
    exp_xact(0, 1'b1, 23'h000010, 32'h1234_5678, '0, 1'b0);
    xact(0, 1'b1, 23'h000010, 32'h1234_5678, 50, lat);
    check("wr_latency", lat, 3);

    // m1 read, data returns 5 cycles after the strobe
    exp_xact(1, 1'b0, 23'h000040, '0, 32'hCAFE_F00D, 1'b0);
    fork
      xact(1, 1'b0, 23'h000040, '0, 50, lat);
      ctl_reply(5, 32'hCAFE_F00D, 2'b10, bad);
    join
    check("rd_latency", lat, 8);
    check("rd_gnt_hold", bad, 0);

    // controller busy while command is pending
    bus.ctl_busy = 1'b1;
    exp_xact(0, 1'b1, 23'h000020, 32'hA5A5_A5A5, '0, 1'b0);
    s0 = n_strobe;
    fork
      xact(0, 1'b1, 23'h000020, 32'hA5A5_A5A5, 100, lat);
      begin
        repeat (12) @(negedge clk);
        check("busy_no_strobe", n_strobe, s0);
        check("busy_gnt", bus.gnt, 2'b01);
        @(posedge clk); #1;
        bus.ctl_busy = 1'b0;
      end
    join
    check("busy_one_strobe", n_strobe, s0 + 1);

    // both ports requesting for four transactions
    w = 1 - last_port;
    for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_ARB_RR_EN
      n = (k % 2 == 0) ? w : 1 - w;
`else
      n = 0;
`endif
      if (n == 0)
        exp_xact(0, 1'b1, 23'h000100, 32'h0000_AAAA, '0, 1'b0);
      else
        exp_xact(1, 1'b1, 23'h000200, 32'h0000_BBBB, '0, 1'b0);
    end
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 23'h000100, 32'h0000_AAAA);
    drive(1, 1'b1, 1'b1, 23'h000200, 32'h0000_BBBB);
    n = 0;
    t = 0;
    while (n < 4 && t < 100) begin
      @(negedge clk);
      t++;
      if (bus.m0_ack || bus.m1_ack) n++;
    end
    check("tie_acks", n, 4);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("tie_drained", rsp_q.size(), 0);

    // m0 read with no data ever returned
    exp_xact(0, 1'b0, 23'h000050, '0, 32'hDEAD_BEEF, 1'b1);
    xact(0, 1'b0, 23'h000050, '0, 50, lat);
    check("to_latency", lat, 2 + TO + 1);
    @(negedge clk);
    check("to_idle_gnt", bus.gnt, 0);

    // stray read data outside WAIT_RD must be ignored
    @(posedge clk); #1;
    bus.ctl_out_valid = 1'b1;
    bus.ctl_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    bus.ctl_out_valid = 1'b0;
    bus.ctl_rdata = '0;
    @(negedge clk);
    check("stray_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    check("stray_m1_rdata", bus.m1_rdata, 32'hCAFE_F00D);

    // reset while waiting for read data
    cmd_q.push_back('{addr: 23'h000060, rw: 1'b0,
                      wdata: '0, gnt: 2'b01});
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 23'h000060, '0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.ctl_in_valid && t < 20);
    check("rst_seen_strobe", bus.ctl_in_valid, 1);
    @(negedge clk);
    check("rst_in_wait_gnt", bus.gnt, 2'b01);
    #2;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    #1;
    check_reset("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("midrst_hold");
    model_rd[0] = '0;
    model_rd[1] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    exp_xact(1, 1'b1, 23'h000300, 32'h0BAD_F00D, '0, 1'b0);
    xact(1, 1'b1, 23'h000300, 32'h0BAD_F00D, 50, lat);
    check("post_rst_latency", lat, 3);

    repeat (3) @(negedge clk);
    check("cmd_q_empty", cmd_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
